// File: rtl/mpu_matrix_loader_if.sv
// Handshake and data bundle between the element stream source, the loader and its matrix consumer.
// Latency: none, this file only groups wires.
// Backpressure: in_ready toward the stream source, out_ready from the matrix consumer.
interface mpu_matrix_loader_if #(
    parameter int ELEM_W = 8
);
    logic                 flush;
    logic                 in_valid;
    logic [ELEM_W-1:0]    in_data;
    logic                 in_last;
    logic                 in_ready;
    logic                 out_valid;
    logic                 out_ready;
    logic [25*ELEM_W-1:0] matrix;
    logic [4:0]           beat_count;
    logic                 err;

    // Stream source and matrix consumer side.
    modport master (
        output flush, in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, matrix, beat_count, err
    );

    // Loader side.
    modport slave (
        input  flush, in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, matrix, beat_count, err
    );
endinterface

// File: rtl/mpu_matrix_loader.sv
// Assembles 25 row-major stream elements into one column-major 5x5 matrix word and checks framing.
// Latency: out_valid rises 1 cycle after the 25th beat; err pulses 1 cycle after a bad beat.
// Backpressure: in_ready=0 while a finished matrix waits (MPU_MATRIX_LOADER_DBUF_EN: only when both buffers are full).
module mpu_matrix_loader #(
    parameter int ELEM_W = 8,
    parameter int DIM    = 5
) (
    input logic                clk,
    input logic                rst_n,
    mpu_matrix_loader_if.slave bus
);
    localparam int NELEM = DIM * DIM;
    localparam int MAT_W = NELEM * ELEM_W;

    if (DIM != 5) begin : g_dim_check
        $error("mpu_matrix_loader: DIM must be 5");
    end

`ifdef MPU_MATRIX_LOADER_DBUF_EN
    typedef enum logic [1:0] {LOAD, HOLD, HOLD_LOAD, HOLD_FULL} state_t;
`else
    typedef enum logic {LOAD, HOLD} state_t;
`endif

    state_t             state, state_nxt;
    logic [4:0]         beat_count, cnt_nxt;
    logic               err_q;
    logic [MAT_W-1:0]   matrix_q;
    logic [MAT_W-1:0]   buf_src, buf_wr;
    logic               in_ready, out_valid;
    logic               accept, hs, last_slot, done, frame_err;
    logic [4:0]         k_row, k_col, wr_pos;

`ifdef MPU_MATRIX_LOADER_DBUF_EN
    logic [MAT_W-1:0]   asm_q;
    assign in_ready = (state != HOLD_FULL);
    assign buf_src  = asm_q;
`else
    assign in_ready = (state == LOAD);
    assign buf_src  = matrix_q;
`endif
    assign out_valid = (state != LOAD);

    assign accept    = bus.in_valid && in_ready;
    assign hs        = out_valid && bus.out_ready;
    assign last_slot = (beat_count == 5'd24);
    assign done      = accept && last_slot && bus.in_last;
    // in_last must coincide exactly with the 25th beat; either mismatch is a framing error.
    assign frame_err = accept && (last_slot != bus.in_last);

    // Stream is row-major, storage is column-major: beat k lands at r + 5*c.
    assign k_row  = beat_count / 5'd5;
    assign k_col  = beat_count % 5'd5;
    assign wr_pos = k_row + 5'd5 * k_col;

    // Merge the incoming element into the assembly buffer image.
    always_comb begin
        buf_wr = buf_src;
        buf_wr[int'(wr_pos) * ELEM_W +: ELEM_W] = bus.in_data;
    end

    // Beat counter: restarts on completion, on any framing error and on flush.
    always_comb begin
        cnt_nxt = beat_count;
        if (bus.flush) begin
            cnt_nxt = 5'd0;
        end else if (accept) begin
            cnt_nxt = (last_slot || bus.in_last) ? 5'd0 : beat_count + 5'd1;
        end
    end

    // Next-state logic; flush always returns to LOAD with nothing held.
    always_comb begin
        state_nxt = state;
        if (bus.flush) begin
            state_nxt = LOAD;
        end else begin
`ifdef MPU_MATRIX_LOADER_DBUF_EN
            if (done && (state == LOAD || hs)) begin
                state_nxt = HOLD;
            end else if (done) begin
                state_nxt = HOLD_FULL;
            end else if (state == HOLD_FULL) begin
                state_nxt = hs ? HOLD : HOLD_FULL;
            end else if (state != LOAD && hs) begin
                state_nxt = LOAD;
            end else if (state != LOAD) begin
                state_nxt = (cnt_nxt != 5'd0) ? HOLD_LOAD : HOLD;
            end
`else
            case (state)
                LOAD:    if (done) state_nxt = HOLD;
                HOLD:    if (hs)   state_nxt = LOAD;
                default: state_nxt = LOAD;
            endcase
`endif
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= LOAD;
        else        state <= state_nxt;
    end

    // Beat counter and one-cycle framing error pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_count <= 5'd0;
            err_q      <= 1'b0;
        end else begin
            beat_count <= cnt_nxt;
            err_q      <= !bus.flush && frame_err;
        end
    end

`ifdef MPU_MATRIX_LOADER_DBUF_EN
    // Assembly buffer fills independently; the output register takes a frame when it completes
    // into a free output slot, or from the assembly buffer once a held matrix is consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            asm_q    <= '0;
            matrix_q <= '0;
        end else if (!bus.flush) begin
            if (accept) asm_q <= buf_wr;
            if (done && (state == LOAD || hs)) begin
                matrix_q <= buf_wr;
            end else if (state == HOLD_FULL && hs) begin
                matrix_q <= asm_q;
            end
        end
    end
`else
    // Single buffer: elements are written straight into the output register; it cannot change
    // while held because in_ready is low in HOLD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                      matrix_q <= '0;
        else if (!bus.flush && accept)   matrix_q <= buf_wr;
    end
`endif

    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = out_valid;
    assign bus.matrix     = matrix_q;
    assign bus.beat_count = beat_count;
    assign bus.err        = err_q;
endmodule

// File: tb/tb_mpu_matrix_loader.sv
// Self-checking bench for mpu_matrix_loader: per-cycle vector table plus hand-written corner sequences,
// with a scoreboard queue checking every matrix handshake.
// Build with MPU_MATRIX_LOADER_DBUF_EN to also exercise the double-buffered variant.
module tb_mpu_matrix_loader;
`ifdef MPU_MATRIX_LOADER_DBUF_EN
    localparam logic DBUF = 1'b1;
`else
    localparam logic DBUF = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mpu_matrix_loader_if #(.ELEM_W(8)) bus ();

    mpu_matrix_loader #(.ELEM_W(8), .DIM(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       l;
        logic       ordy;
        logic       fl;
        logic       e_rdy;
        logic       e_vld;
        logic [4:0] e_cnt;
        logic       e_err;
    } vec_t;

    vec_t         tbl [37];
    int           n_vec = 0;
    int           n_err = 0;
    logic [199:0] exp_q [$];

    task automatic check(string nm, logic [199:0] act, logic [199:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endtask

    function automatic vec_t mk(logic v, logic [7:0] d, logic l, logic o, logic f,
                                logic er, logic ev, logic [4:0] ec, logic ee);
        vec_t t;
        t.v = v; t.d = d; t.l = l; t.ordy = o; t.fl = f;
        t.e_rdy = er; t.e_vld = ev; t.e_cnt = ec; t.e_err = ee;
        return t;
    endfunction

    // Reference matrix for a frame whose beat k carries base+k, stream row-major.
    function automatic logic [199:0] model(logic [7:0] base);
        logic [199:0] m;
        m = '0;
        for (int k = 0; k < 25; k++) begin
            m[8*((k/5) + 5*(k%5)) +: 8] = base + 8'(k);
        end
        return m;
    endfunction

    function automatic logic [7:0] elem(logic [199:0] m, int r, int c);
        return m[8*(r + 5*c) +: 8];
    endfunction

    task automatic cyc(logic v, logic [7:0] d, logic l, logic ordy, logic fl);
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.in_last   = l;
        bus.out_ready = ordy;
        bus.flush     = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(logic ordy);
        cyc(1'b0, 8'h00, 1'b0, ordy, 1'b0);
    endtask

    task automatic send_frame(logic [7:0] base, int n, int last_at, logic ordy);
        for (int k = 0; k < n; k++) begin
            cyc(1'b1, base + 8'(k), (k == last_at), ordy, 1'b0);
        end
    endtask

    task automatic apply(int i);
        cyc(tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].ordy, tbl[i].fl);
        check($sformatf("vec%0d_in_ready", i),   bus.in_ready,   tbl[i].e_rdy);
        check($sformatf("vec%0d_out_valid", i),  bus.out_valid,  tbl[i].e_vld);
        check($sformatf("vec%0d_beat_count", i), bus.beat_count, tbl[i].e_cnt);
        check($sformatf("vec%0d_err", i),        bus.err,        tbl[i].e_err);
    endtask

    // Scoreboard: every matrix handshake must match the oldest expected frame.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL sb_unexpected: got matrix %0h expected no output", bus.matrix);
                end else begin
                    check("sb_matrix", bus.matrix, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout: got no finish expected finish within bound");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
        $fatal(1, "timeout");
    end

    initial begin
        // Frame 1..25 with consumer ready, then one idle cycle in which it is consumed.
        for (int k = 0; k < 25; k++) begin
            tbl[k] = mk(1'b1, 8'(k + 1), (k == 24), 1'b1, 1'b0,
                        (k == 24) ? DBUF : 1'b1, (k == 24), (k == 24) ? 5'd0 : 5'(k + 1), 1'b0);
        end
        tbl[25] = mk(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0);
        // Early in_last on beat 10, then an idle cycle to see the pulse end.
        for (int k = 0; k < 10; k++) begin
            tbl[26 + k] = mk(1'b1, 8'h30 + 8'(k), (k == 9), 1'b1, 1'b0,
                             1'b1, 1'b0, (k == 9) ? 5'd0 : 5'(k + 1), (k == 9));
        end
        tbl[36] = mk(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0);

        // Reset state.
        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.in_data = 8'h00; bus.in_last = 1'b0;
        bus.out_ready = 1'b0; bus.flush = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready",   bus.in_ready,   1'b1);
        check("rst_out_valid",  bus.out_valid,  1'b0);
        check("rst_matrix",     bus.matrix,     200'd0);
        check("rst_beat_count", bus.beat_count, 5'd0);
        check("rst_err",        bus.err,        1'b0);
        rst_n = 1'b1;

        // Basic frame, 1-cycle output latency, element placement.
        exp_q.push_back(model(8'd1));
        for (int i = 0; i < 26; i++) begin
            apply(i);
            if (i == 24) begin
                check("elem_0_0", elem(bus.matrix, 0, 0), 8'd1);
                check("elem_0_1", elem(bus.matrix, 0, 1), 8'd2);
                check("elem_1_0", elem(bus.matrix, 1, 0), 8'd6);
                check("elem_2_3", elem(bus.matrix, 2, 3), 8'd14);
                check("elem_4_4", elem(bus.matrix, 4, 4), 8'd25);
            end
        end

        // Output held under backpressure for 10 cycles, then released.
        exp_q.push_back(model(8'd1));
        send_frame(8'd1, 25, 24, 1'b0);
        for (int i = 0; i < 10; i++) begin
            idle(1'b0);
            check("hold_out_valid", bus.out_valid, 1'b1);
            check("hold_in_ready",  bus.in_ready,  DBUF);
            check("hold_matrix",    bus.matrix,    model(8'd1));
        end
        idle(1'b1);
        check("release_in_ready",  bus.in_ready,  1'b1);
        check("release_out_valid", bus.out_valid, 1'b0);

        // Early-last error, then a clean frame 0x80..0x98.
        for (int i = 26; i < 37; i++) apply(i);
        exp_q.push_back(model(8'h80));
        send_frame(8'h80, 25, 24, 1'b1);
        check("recover_out_valid", bus.out_valid, 1'b1);
        check("recover_elem_4_4",  elem(bus.matrix, 4, 4), 8'h98);
        idle(1'b1);
        check("recover_consumed", bus.out_valid, 1'b0);

        // Missing last on the 25th beat.
        send_frame(8'h40, 25, -1, 1'b1);
        check("nolast_err",        bus.err,        1'b1);
        check("nolast_out_valid",  bus.out_valid,  1'b0);
        check("nolast_beat_count", bus.beat_count, 5'd0);
        idle(1'b1);
        check("nolast_err_end",    bus.err,        1'b0);
        check("nolast_no_output",  bus.out_valid,  1'b0);

        // Flush on beat 12 of a frame; that beat is dropped.
        send_frame(8'h50, 11, -1, 1'b1);
        check("preflush_beat_count", bus.beat_count, 5'd11);
        cyc(1'b1, 8'h5b, 1'b0, 1'b1, 1'b1);
        check("flush_beat_count", bus.beat_count, 5'd0);
        check("flush_in_ready",   bus.in_ready,   1'b1);
        check("flush_out_valid",  bus.out_valid,  1'b0);
        check("flush_err",        bus.err,        1'b0);
        exp_q.push_back(model(8'h60));
        send_frame(8'h60, 25, 24, 1'b1);
        check("postflush_out_valid", bus.out_valid, 1'b1);
        idle(1'b1);
        check("postflush_consumed", bus.out_valid, 1'b0);

        // Reset asserted while a matrix is held.
        send_frame(8'h10, 25, 24, 1'b0);
        check("prereset_out_valid", bus.out_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        check("midreset_out_valid",  bus.out_valid,  1'b0);
        check("midreset_in_ready",   bus.in_ready,   1'b1);
        check("midreset_matrix",     bus.matrix,     200'd0);
        check("midreset_beat_count", bus.beat_count, 5'd0);
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

`ifdef MPU_MATRIX_LOADER_DBUF_EN
        // Two back-to-back frames with the consumer stalled, then drained.
        exp_q.push_back(model(8'd1));
        exp_q.push_back(model(8'd26));
        send_frame(8'd1, 25, 24, 1'b0);
        check("dbuf_hold_in_ready", bus.in_ready, 1'b1);
        send_frame(8'd26, 25, 24, 1'b0);
        check("dbuf_full_in_ready",  bus.in_ready,  1'b0);
        check("dbuf_full_out_valid", bus.out_valid, 1'b1);
        check("dbuf_full_elem_0_0",  elem(bus.matrix, 0, 0), 8'd1);
        idle(1'b1);
        check("dbuf_swap_out_valid", bus.out_valid, 1'b1);
        check("dbuf_swap_elem_0_0",  elem(bus.matrix, 0, 0), 8'd26);
        check("dbuf_swap_elem_4_4",  elem(bus.matrix, 4, 4), 8'd50);
        check("dbuf_swap_in_ready",  bus.in_ready,  1'b1);
        idle(1'b1);
        check("dbuf_drained_out_valid", bus.out_valid, 1'b0);
        idle(1'b0);
`endif

        check("sb_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
